// File: rtl/fp_multiplier_seq_pkg.sv
// Shared IEEE-754 single-precision field helpers and constants for the FP ALU units.
package fp_multiplier_seq_pkg;

  localparam logic [31:0] FP_NAN     = 32'h7FC0_0000;
  localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam int          FP_BIAS    = 127;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [23:0] fp_mant_full(input logic [31:0] x);
    return {1'b1, x[22:0]};
  endfunction

  // Subnormals are flushed, so any zero exponent classifies as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == 8'h00;
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
  endfunction

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
  endfunction

endpackage

// File: rtl/fp_mant_mul_iter.sv
// 24x24 shift-add mantissa engine: one partial product per cycle after load.
module fp_mant_mul_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [47:0] p,
  output logic        last
);

  logic [23:0] ma_q, ma_d;
  logic [23:0] mb_q, mb_d;
  logic [47:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        active_q, active_d;

  always_comb begin
    ma_d     = ma_q;
    mb_d     = mb_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      ma_d     = ma;
      mb_d     = mb;
      p_d      = 48'h0;
      cnt_d    = 5'd0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (mb_q[cnt_q])
        p_d = p_q + ({24'h0, ma_q} << cnt_q);
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd23)
        active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma_q     <= '0;
      mb_q     <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // High during the final iteration so the owner can step on the same edge.
  assign last = active_q && (cnt_q == 5'd23) && !load;
  assign p    = p_q;

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle IEEE-754 single multiplier with truncation rounding and start/done handshake.
module fp_multiplier_seq
  import fp_multiplier_seq_pkg::*;
#(
  parameter int          EXP_BIAS  = FP_BIAS,
  parameter logic [31:0] CANON_NAN = FP_NAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  typedef enum logic [2:0] {IDLE, LOAD, MULT, NORM, FINISH} state_e;

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        result_q, result_d;
  logic signed [9:0]  exp_q, exp_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic               ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;

  logic               eng_load, eng_last;
  logic [47:0]        eng_p;
  logic               sign;
  logic signed [9:0]  e_norm;
  logic [22:0]        mant;
  logic               unused_p_low;

  fp_mant_mul_iter u_mant (
    .clk   (clk),
    .reset (reset),
    .load  (eng_load),
    .ma    (fp_mant_full(a_q)),
    .mb    (fp_mant_full(b_q)),
    .p     (eng_p),
    .last  (eng_last)
  );

  assign sign         = fp_sign(a_q) ^ fp_sign(b_q);
  assign unused_p_low = ^eng_p[22:0];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    exp_d    = exp_q;
    done_d   = done_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inv_d    = inv_q;
    eng_load = 1'b0;
    e_norm   = exp_q;
    mant     = eng_p[45:23];

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          a_d     = a;
          b_d     = b;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          inv_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = FINISH;
        if (is_nan(a_q) || is_nan(b_q) ||
            (is_inf(a_q) && is_zero(b_q)) || (is_zero(a_q) && is_inf(b_q))) begin
          result_d = CANON_NAN;
          inv_d    = 1'b1;
        end else if (is_inf(a_q) || is_inf(b_q)) begin
          result_d = {sign, FP_POS_INF[30:0]};
        end else if (is_zero(a_q) || is_zero(b_q)) begin
          result_d = {sign, FP_ZERO[30:0]};
        end else begin
          eng_load = 1'b1;
          exp_d    = 10'({2'b00, fp_exp(a_q)}) + 10'({2'b00, fp_exp(b_q)}) - 10'(EXP_BIAS);
          state_d  = MULT;
        end
      end
      MULT: begin
        if (eng_last)
          state_d = NORM;
      end
      NORM: begin
        // Product of two [1,2) mantissas lies in [1,4); bit 47 selects the one-bit renormalise.
        if (eng_p[47]) begin
          mant   = eng_p[46:24];
          e_norm = exp_q + 10'sd1;
        end
        if (e_norm >= 10'sd255) begin
          result_d = {sign, FP_POS_INF[30:0]};
          ovf_d    = 1'b1;
        end else if (e_norm <= 10'sd0) begin
          result_d = {sign, FP_ZERO[30:0]};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign, e_norm[7:0], mant};
        end
        state_d = FINISH;
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exp_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inv_q    <= inv_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Directed-vector bench for fp_multiplier_seq with hand-computed products, latencies and flags.
module tb_fp_multiplier_seq;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a, b, result;
   logic        done, busy, overflow, underflow, invalid;

   int checks = 0;
   int errors = 0;

   // Free-running 10 ns clock
   always #5 clock = ~clock;

   fp_multiplier_seq dut (
      .clk       (clock),
      .reset     (reset),
      .a         (a),
      .b         (b),
      .start     (start),
      .result    (result),
      .done      (done),
      .busy      (busy),
      .overflow  (overflow),
      .underflow (underflow),
      .invalid   (invalid)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Launches one operation, optionally re-pulses start with other operands at edge N+disturbAt,
   // then checks latency, result, flags and the busy/done handshake
   task automatic applyStimulus(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                                input logic [31:0] expResult, input logic [2:0] expFlags,
                                input int expLat, input int disturbAt);
      int   lat;
      logic busyLow;
      @(negedge clock);
      a = opA; b = opB; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      checkOutput({tag, " busy_after_accept"}, {31'b0, busy}, 32'd1);
      lat = 0;
      busyLow = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         if (n == disturbAt) begin
            @(negedge clock);
            start = 1'b1; a = 32'h3FC0_0000; b = 32'hBFC0_0000;
         end
         @(posedge clock); #1;
         start = 1'b0;
         if (done) begin
            lat = n;
            break;
         end
         if (!busy) busyLow = 1'b1;
      end
      checkOutput({tag, " latency"}, lat, expLat);
      checkOutput({tag, " result"}, result, expResult);
      checkOutput({tag, " flags"}, {29'b0, overflow, underflow, invalid}, {29'b0, expFlags});
      checkOutput({tag, " busy_during_op"}, {30'b0, busyLow, busy}, 32'd1);
      @(posedge clock); #1;
      checkOutput({tag, " done_busy_fall"}, {30'b0, done, busy}, 32'd0);
   endtask

   // Directed sequence
   initial begin
      logic seenDone;
      int   gap;
      reset = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset result", result, 32'h0);
      checkOutput("reset ctrl", {27'b0, done, busy, overflow, underflow, invalid}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      applyStimulus("3x2",       32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000, 27, 0);
      applyStimulus("1.5x-1.5",  32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 3'b000, 27, 0);
      applyStimulus("overflow",  32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100, 27, 0);
      applyStimulus("underflow", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010, 27, 0);
      applyStimulus("inf*-0",    32'h7F80_0000, 32'h8000_0000, 32'h7FC0_0000, 3'b001, 2, 0);
      applyStimulus("nan",       32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b001, 2, 0);
      applyStimulus("-inf*2",    32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000, 2, 0);
      applyStimulus("-0*3",      32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 3'b000, 2, 0);
      applyStimulus("disturb",   32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 3'b000, 27, 10);

      // Reset at N+10 aborts the operation without a done pulse
      @(negedge clock);
      a = 32'h3FC0_0000; b = 32'hBFC0_0000; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midreset result", result, 32'h0);
      checkOutput("midreset ctrl", {27'b0, done, busy, overflow, underflow, invalid}, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      seenDone = 1'b0;
      repeat (30) begin
         @(posedge clock); #1;
         if (done) seenDone = 1'b1;
      end
      checkOutput("midreset no_done", {31'b0, seenDone}, 32'd0);
      applyStimulus("after_reset", 32'h3FC0_0000, 32'hBFC0_0000, 32'hC010_0000, 3'b000, 27, 0);

      // Start held high: second operation accepted in the first IDLE cycle after done
      @(negedge clock);
      a = 32'h4040_0000; b = 32'h4000_0000; start = 1'b1;
      gap = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock); #1;
         if (done) begin
            gap = n;
            break;
         end
      end
      checkOutput("held first_latency", gap, 28);
      checkOutput("held first_result", result, 32'h40C0_0000);
      a = 32'h3FC0_0000; b = 32'hBFC0_0000;
      @(posedge clock); #1;
      start = 1'b0;
      checkOutput("held reaccept", {30'b0, done, busy}, 32'd1);
      gap = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock); #1;
         if (done) begin
            gap = n;
            break;
         end
      end
      checkOutput("held second_latency", gap, 27);
      checkOutput("held second_result", result, 32'hC010_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
